// File: rtl/spi_pkg.sv
// Shared types and constants for the single-byte SPI master.
package spi_pkg;

    localparam int SPI_WIDTH  = 8;
    localparam int EDGE_TOTAL = 2 * SPI_WIDTH;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3
    } spi_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: one strobe per half-period while enabled, SCLK parked at the idle level otherwise.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic idle_level,
    output logic sclk,
    output logic lead_edge,
    output logic trail_edge,
    output logic period_end
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt_reg;
    logic          sclk_reg;
    logic          tick;

    // The strobe fires in the first cycle of each half-period, so SCLK moves one clock
    // after SHIFT is entered and then every CLK_DIV clocks.
    assign tick       = en && (div_cnt_reg == '0);
    assign period_end = en && (div_cnt_reg == DIV_LAST);
    assign lead_edge  = tick && (sclk_reg == idle_level);
    assign trail_edge = tick && (sclk_reg != idle_level);
    assign sclk       = sclk_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_reg <= '0;
            sclk_reg    <= 1'b0;
        end else if (!en) begin
            div_cnt_reg <= '0;
            sclk_reg    <= idle_level;
        end else begin
            div_cnt_reg <= period_end ? '0 : div_cnt_reg + 1'b1;
            if (tick) begin
                sclk_reg <= ~sclk_reg;
            end
        end
    end

endmodule

// File: rtl/spi_master.sv
// Single-byte full-duplex SPI master, MSB first, all four CPOL/CPHA modes.
// Transfer framing: SETUP (CLK_DIV clocks) -> SHIFT (16 half-periods) -> DONE (CLK_DIV clocks).
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read,
    input  logic                 write,
    input  logic [SPI_WIDTH-1:0] datain,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic                 miso,
    output logic                 sclk,
    output logic                 mosi,
    output logic                 ss,
    output logic [2:0]           stateout,
    output logic [SPI_WIDTH-1:0] miso_dataout
);

    localparam int CW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int ECW = $clog2(EDGE_TOTAL + 1);
    localparam logic [CW-1:0]  WAIT_LAST     = CW'(CLK_DIV - 1);
    localparam logic [ECW-1:0] EDGE_FINAL    = ECW'(EDGE_TOTAL);
    localparam logic [ECW-1:0] EDGE_LAST_IDX = ECW'(EDGE_TOTAL - 1);

    spi_state_e state_reg, state_next;

    logic [CW-1:0]        wait_cnt_reg, wait_cnt_next;
    logic [ECW-1:0]       edge_cnt_reg, edge_cnt_next;
    logic [SPI_WIDTH-1:0] tx_shift_reg, tx_shift_next;
    logic [SPI_WIDTH-1:0] rx_shift_reg, rx_shift_next;
    logic [SPI_WIDTH-1:0] miso_data_reg, miso_data_next;
    logic                 cpol_lat_reg, cpol_lat_next;
    logic                 cpha_lat_reg, cpha_lat_next;
    logic                 read_lat_reg, read_lat_next;
    logic                 write_lat_reg, write_lat_next;
    logic                 ss_reg, ss_next;
    logic                 mosi_reg, mosi_next;

    logic sclk_en;
    logic sclk_idle;
    logic lead_edge;
    logic trail_edge;
    logic period_end;
    logic sample_edge;
    logic drive_edge;

    // In IDLE the live cpol sets the parked level; once a transfer starts the latched copy does.
    assign sclk_en   = (state_reg == SHIFT);
    assign sclk_idle = (state_reg == IDLE) ? cpol : cpol_lat_reg;

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .reset     (reset),
        .en        (sclk_en),
        .idle_level(sclk_idle),
        .sclk      (sclk),
        .lead_edge (lead_edge),
        .trail_edge(trail_edge),
        .period_end(period_end)
    );

    assign stateout     = state_reg;
    assign ss           = ss_reg;
    assign mosi         = mosi_reg;
    assign miso_dataout = miso_data_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_reg  <= '0;
            edge_cnt_reg  <= '0;
            tx_shift_reg  <= '0;
            rx_shift_reg  <= '0;
            miso_data_reg <= '0;
            cpol_lat_reg  <= 1'b0;
            cpha_lat_reg  <= 1'b0;
            read_lat_reg  <= 1'b0;
            write_lat_reg <= 1'b0;
            ss_reg        <= 1'b1;
            mosi_reg      <= 1'b0;
        end else begin
            wait_cnt_reg  <= wait_cnt_next;
            edge_cnt_reg  <= edge_cnt_next;
            tx_shift_reg  <= tx_shift_next;
            rx_shift_reg  <= rx_shift_next;
            miso_data_reg <= miso_data_next;
            cpol_lat_reg  <= cpol_lat_next;
            cpha_lat_reg  <= cpha_lat_next;
            read_lat_reg  <= read_lat_next;
            write_lat_reg <= write_lat_next;
            ss_reg        <= ss_next;
            mosi_reg      <= mosi_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = '0;
        edge_cnt_next  = edge_cnt_reg;
        tx_shift_next  = tx_shift_reg;
        rx_shift_next  = rx_shift_reg;
        miso_data_next = miso_data_reg;
        cpol_lat_next  = cpol_lat_reg;
        cpha_lat_next  = cpha_lat_reg;
        read_lat_next  = read_lat_reg;
        write_lat_next = write_lat_reg;
        ss_next        = ss_reg;
        mosi_next      = mosi_reg;
        sample_edge    = 1'b0;
        drive_edge     = 1'b0;

        case (state_reg)
            IDLE: begin
                ss_next   = 1'b1;
                mosi_next = 1'b0;
                if (read || write) begin
                    state_next     = SETUP;
                    cpol_lat_next  = cpol;
                    cpha_lat_next  = cpha;
                    read_lat_next  = read;
                    write_lat_next = write;
                    edge_cnt_next  = '0;
                    rx_shift_next  = '0;
                    ss_next        = 1'b0;
                    // CPHA=0 presents bit 7 during SETUP, so the shifter starts one bit ahead.
                    if (cpha) begin
                        tx_shift_next = datain;
                        mosi_next     = 1'b0;
                    end else begin
                        tx_shift_next = {datain[SPI_WIDTH-2:0], 1'b0};
                        mosi_next     = write && datain[SPI_WIDTH-1];
                    end
                end
            end

            SETUP: begin
                if (wait_cnt_reg == WAIT_LAST) begin
                    state_next = SHIFT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end

            SHIFT: begin
                sample_edge = cpha_lat_reg ? trail_edge : lead_edge;
                drive_edge  = cpha_lat_reg ? lead_edge
                                           : (trail_edge && (edge_cnt_reg != EDGE_LAST_IDX));
                if (lead_edge || trail_edge) begin
                    edge_cnt_next = edge_cnt_reg + 1'b1;
                end
                if (sample_edge) begin
                    rx_shift_next = {rx_shift_reg[SPI_WIDTH-2:0], miso};
                end
                if (drive_edge) begin
                    mosi_next     = write_lat_reg && tx_shift_reg[SPI_WIDTH-1];
                    tx_shift_next = {tx_shift_reg[SPI_WIDTH-2:0], 1'b0};
                end
                // Hold the final half-period after the 16th edge before closing the frame.
                if ((edge_cnt_reg == EDGE_FINAL) && period_end) begin
                    state_next = DONE;
                    if (read_lat_reg) begin
                        miso_data_next = rx_shift_reg;
                    end
                end
            end

            DONE: begin
                if (wait_cnt_reg == WAIT_LAST) begin
                    state_next = IDLE;
                    ss_next    = 1'b1;
                    mosi_next  = 1'b0;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                ss_next    = 1'b1;
                mosi_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: mode coverage, read/write-only, back-to-back and reset abort.
module tb_spi_master;

    localparam int CLK_DIV = 4;

    logic       clk;
    logic       reset;
    logic       read_in;
    logic       write_in;
    logic [7:0] datain_in;
    logic       cpol_in;
    logic       cpha_in;
    logic       miso;
    logic       miso_drv;
    logic       loop_en;
    logic       sclk;
    logic       mosi;
    logic       ss;
    logic [2:0] stateout;
    logic [7:0] miso_dataout;

    int errors = 0;
    int checks = 0;

    int         edges, ss_low, lat, gap;
    logic [7:0] tx_seen;
    bit         mosi_zero, seq_ok;

    spi_master #(
        .CLK_DIV(CLK_DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .read        (read_in),
        .write       (write_in),
        .datain      (datain_in),
        .cpol        (cpol_in),
        .cpha        (cpha_in),
        .miso        (miso),
        .sclk        (sclk),
        .mosi        (mosi),
        .ss          (ss),
        .stateout    (stateout),
        .miso_dataout(miso_dataout)
    );

    assign miso = loop_en ? mosi : miso_drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one request and follows it, sampling every falling clk edge until ss rises again.
    task automatic xfer(input logic r, input logic w, input logic pol, input logic pha,
                        input logic [7:0] d, input logic [7:0] d_after, input bit hold,
                        output int n_edges, output int n_low, output int first_lat,
                        output int n_gap, output logic [7:0] seen, output bit zero_mosi,
                        output bit seq_good);
        logic       prev_sclk;
        logic       mosi_prev;
        logic       lead;
        logic [2:0] prev_state;
        int         n;
        int         changes;
        int         bad;
        read_in   = r;
        write_in  = w;
        cpol_in   = pol;
        cpha_in   = pha;
        datain_in = d;
        n_gap = 0;
        while (ss !== 1'b0 && n_gap < 50) begin
            n_gap++;
            @(negedge clk);
        end
        datain_in = d_after;
        if (!hold) begin
            read_in  = 1'b0;
            write_in = 1'b0;
        end
        n_edges = 0; n_low = 0; first_lat = -1; seen = 8'h00; zero_mosi = 1'b1;
        changes = 0; bad = 0; prev_state = 3'd0; n = 0;
        prev_sclk = sclk;
        while (ss === 1'b0 && n < 200) begin
            n_low++;
            if (stateout !== prev_state) begin
                changes++;
                if (stateout !== ((prev_state + 3'd1) & 3'd3)) bad++;
                prev_state = stateout;
            end
            if (mosi !== 1'b0) zero_mosi = 1'b0;
            mosi_prev = mosi;
            @(negedge clk);
            n++;
            if (sclk !== prev_sclk) begin
                n_edges++;
                if (first_lat < 0) first_lat = n;
                lead = (prev_sclk === pol);
                if (pha ? !lead : lead) seen = {seen[6:0], mosi_prev};
                prev_sclk = sclk;
            end
        end
        if (stateout !== prev_state) begin
            changes++;
            if (stateout !== ((prev_state + 3'd1) & 3'd3)) bad++;
        end
        seq_good = (bad == 0) && (changes == 4) && (ss === 1'b1);
    endtask

    initial begin
        reset = 1'b0; read_in = 1'b0; write_in = 1'b0; datain_in = 8'h00;
        cpol_in = 1'b0; cpha_in = 1'b0; miso_drv = 1'b0; loop_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", stateout, 3'd0);
        check("rst_ss", ss, 1'b1);
        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_data", miso_dataout, 8'h00);
        reset = 1'b1;
        @(negedge clk);
        check("idle_state", stateout, 3'd0);

        // Mode 1 full duplex, MISO held high.
        miso_drv = 1'b1;
        xfer(1'b1, 1'b1, 1'b0, 1'b1, 8'hE5, 8'h1A, 1'b0, edges, ss_low, lat, gap, tx_seen, mosi_zero, seq_ok);
        check("m1_mosi", tx_seen, 8'hE5);
        check("m1_edges", edges, 16);
        check("m1_sslow", ss_low, 18 * CLK_DIV);
        check("m1_latency", lat, 1 + CLK_DIV);
        check("m1_seq", seq_ok, 1'b1);
        check("m1_data", miso_dataout, 8'hFF);

        // Mode 0 loopback.
        loop_en = 1'b1;
        xfer(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h5A, 1'b0, edges, ss_low, lat, gap, tx_seen, mosi_zero, seq_ok);
        check("m0_mosi", tx_seen, 8'hA5);
        check("m0_edges", edges, 16);
        check("m0_latency", lat, 1 + CLK_DIV);
        check("m0_data", miso_dataout, 8'hA5);

        // Mode 3 loopback, SCLK parked high.
        cpol_in = 1'b1;
        @(negedge clk);
        check("m3_idle_sclk", sclk, 1'b1);
        xfer(1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 8'hC3, 1'b0, edges, ss_low, lat, gap, tx_seen, mosi_zero, seq_ok);
        check("m3_edges", edges, 16);
        check("m3_mosi", tx_seen, 8'h3C);
        check("m3_seq", seq_ok, 1'b1);
        check("m3_end_sclk", sclk, 1'b1);
        check("m3_data", miso_dataout, 8'h3C);

        // Write-only keeps the last received byte; read-only never drives MOSI.
        loop_en = 1'b0; miso_drv = 1'b0;
        xfer(1'b0, 1'b1, 1'b0, 1'b0, 8'h96, 8'h00, 1'b0, edges, ss_low, lat, gap, tx_seen, mosi_zero, seq_ok);
        check("wo_mosi", tx_seen, 8'h96);
        check("wo_data_hold", miso_dataout, 8'h3C);
        xfer(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, edges, ss_low, lat, gap, tx_seen, mosi_zero, seq_ok);
        check("ro_mosi_zero", mosi_zero, 1'b1);
        check("ro_edges", edges, 16);
        check("ro_data", miso_dataout, 8'h00);

        // Back-to-back mode 2 loopback with request held; second byte loaded mid-transfer.
        loop_en = 1'b1;
        xfer(1'b1, 1'b1, 1'b1, 1'b0, 8'h55, 8'hAA, 1'b1, edges, ss_low, lat, gap, tx_seen, mosi_zero, seq_ok);
        check("b2b1_data", miso_dataout, 8'h55);
        check("b2b1_seq", seq_ok, 1'b1);
        xfer(1'b1, 1'b1, 1'b1, 1'b0, 8'hAA, 8'h00, 1'b0, edges, ss_low, lat, gap, tx_seen, mosi_zero, seq_ok);
        check("b2b_gap", gap, 1);
        check("b2b2_mosi", tx_seen, 8'hAA);
        check("b2b2_seq", seq_ok, 1'b1);
        check("b2b2_data", miso_dataout, 8'hAA);

        // Mode 3 transfer aborted by reset after the sixth SCLK edge.
        read_in = 1'b1; write_in = 1'b1; cpol_in = 1'b1; cpha_in = 1'b1; datain_in = 8'hFF;
        begin
            int n;
            logic prev;
            n = 0;
            while (ss !== 1'b0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            read_in = 1'b0; write_in = 1'b0;
            edges = 0; n = 0;
            while (edges < 6 && n < 200) begin
                prev = sclk;
                @(negedge clk);
                n++;
                if (sclk !== prev) edges++;
            end
        end
        check("ab_edges", edges, 6);
        check("ab_pre_sclk", sclk, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("ab_state", stateout, 3'd0);
        check("ab_ss", ss, 1'b1);
        check("ab_sclk", sclk, 1'b0);
        check("ab_mosi", mosi, 1'b0);
        check("ab_data", miso_dataout, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("ab_post_state", stateout, 3'd0);
        check("ab_post_data", miso_dataout, 8'h00);
        check("ab_post_sclk", sclk, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
